// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS-subset control unit: Moore FSM sequencing PC, IR, ALU and
// memory control, plus a retired-instruction counter and sticky illegal flag.
module mc_ctrl_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             write_reg,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state_o,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    // state  | meaning
    // S_IDLE | waiting for run
    // S_IF   | fetch, PC <= PC+4
    // S_ID   | decode, precompute branch target
    // S_EXR  | R-type execute
    // S_WBR  | R-type writeback to rd
    // S_EXI  | addi execute
    // S_WBI  | addi writeback to rt
    // S_ADDR | lw/sw address compute
    // S_MRD  | load memory read
    // S_WBL  | load writeback from MDR
    // S_MWR  | store memory write
    // S_BEQ  | branch compare, conditional PC load
    // S_J    | jump
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_IF   = 4'd1,
        S_ID   = 4'd2,
        S_EXR  = 4'd3,
        S_WBR  = 4'd4,
        S_EXI  = 4'd5,
        S_WBI  = 4'd6,
        S_ADDR = 4'd7,
        S_MRD  = 4'd8,
        S_WBL  = 4'd9,
        S_MWR  = 4'd10,
        S_BEQ  = 4'd11,
        S_J    = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       write_reg;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            6'b100010: op = 3'b110;
            6'b100100: op = 3'b000;
            6'b100101: op = 3'b001;
            6'b101010: op = 3'b111;
            default:   op = 3'b010;
        endcase
        return op;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] fn);
        ctrl_t c;
        c        = '0;
        c.alu_op = 3'b010;
        case (s)
            S_IF: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_ID:  c.alu_src_b = 2'b11;
            S_EXR: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = funct_alu(fn);
            end
            S_WBR: begin
                c.write_reg = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_EXI, S_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_WBI: c.write_reg = 1'b1;
            S_MRD: c.mem_read = 1'b1;
            S_WBL: begin
                c.write_reg  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MWR: c.mem_write = 1'b1;
            // pc_write here depends on the live zero flag, added at the output
            S_BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b110;
                c.pc_src    = 2'b01;
            end
            S_J: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t            state_q, state_d;
    ctrl_t             ctrl_q;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              r_ok;
    logic              is_retire;

    always_comb begin
        r_ok      = (opcode == OP_R) &&
                    (funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
        is_retire = state_q inside {S_WBR, S_WBI, S_WBL, S_MWR, S_BEQ, S_J};
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: state_d = run ? S_IF : S_IDLE;
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (r_ok)                                    state_d = S_EXR;
                else if (opcode == OP_ADDI)                  state_d = S_EXI;
                else if (opcode == OP_LW || opcode == OP_SW) state_d = S_ADDR;
                else if (opcode == OP_BEQ)                   state_d = S_BEQ;
                else if (opcode == OP_J)                     state_d = S_J;
                else begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b1;
                end
            end
            S_EXR:  state_d = S_WBR;
            S_EXI:  state_d = S_WBI;
            S_ADDR: state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:  state_d = S_WBL;
            S_WBR, S_WBI, S_WBL, S_MWR, S_BEQ, S_J: state_d = run ? S_IF : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ctrl_q    <= ctrl_for(S_IDLE, 6'd0);
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_for(state_d, funct);
            illegal_q <= illegal_d;
            if (is_retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pc_write    = ctrl_q.pc_write | ((state_q == S_BEQ) & zero);
    assign pc_src      = ctrl_q.pc_src;
    assign ir_write    = ctrl_q.ir_write;
    assign mem_read    = ctrl_q.mem_read;
    assign mem_write   = ctrl_q.mem_write;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign alu_op      = ctrl_q.alu_op;
    assign write_reg   = ctrl_q.write_reg;
    assign reg_dst     = ctrl_q.reg_dst;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign state_o     = state_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: directed scenarios then a random
// instruction mix, compared against an instruction-level reference model.
module tb_mc_ctrl_unit;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, run, zero;
    logic [5:0]    opcode, funct;
    logic          pc_write, ir_write, mem_read, mem_write, alu_src_a;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    alu_op;
    logic          write_reg, reg_dst, mem_to_reg, illegal;
    logic [3:0]    state_o;
    logic [CW-1:0] instr_count;
    logic [14:0]   obs_ctrl;

    mc_ctrl_unit #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .write_reg(write_reg), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state_o(state_o),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign obs_ctrl = {pc_write, pc_src, ir_write, mem_read, mem_write, alu_src_a,
                       alu_src_b, alu_op, write_reg, reg_dst, mem_to_reg};

    int n_cmp = 0;
    int n_bad = 0;
    int mdl_cnt = 0;
    bit mdl_ill = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_r(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // Control word the datapath must see in a given state, from the state table.
    function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] fn, input bit z);
        logic       pw = 1'b0, irw = 1'b0, mr = 1'b0, mw = 1'b0, asa = 1'b0;
        logic       wr = 1'b0, rd = 1'b0, m2r = 1'b0;
        logic [1:0] ps = 2'b00, asb = 2'b00;
        logic [2:0] aop = 3'b010;
        case (st)
            1:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
            2:  asb = 2'b11;
            3:  begin
                    asa = 1;
                    case (fn)
                        6'b100010: aop = 3'b110;
                        6'b100100: aop = 3'b000;
                        6'b100101: aop = 3'b001;
                        6'b101010: aop = 3'b111;
                        default:   aop = 3'b010;
                    endcase
                end
            4:  begin wr = 1; rd = 1; end
            5, 7: begin asa = 1; asb = 2'b10; end
            6:  wr = 1;
            8:  mr = 1;
            9:  begin wr = 1; m2r = 1; end
            10: mw = 1;
            11: begin asa = 1; aop = 3'b110; ps = 2'b01; pw = z; end
            12: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, ps, irw, mr, mw, asa, asb, aop, wr, rd, m2r};
    endfunction

    // Runs one instruction starting at a negedge where S_IF is expected.
    task automatic exec(input logic [5:0] op, input logic [5:0] fn, input bit z, input int drop_at);
        int seq[$];
        bit legal = 1'b1;
        int strobes = 0;
        int exp_strobes;
        opcode = op;
        funct  = fn;
        zero   = z;
        if (op == 6'b000000 && legal_r(fn)) seq = '{1, 2, 3, 4};
        else if (op == 6'b001000)           seq = '{1, 2, 5, 6};
        else if (op == 6'b100011)           seq = '{1, 2, 7, 8, 9};
        else if (op == 6'b101011)           seq = '{1, 2, 7, 10};
        else if (op == 6'b000100)           seq = '{1, 2, 11};
        else if (op == 6'b000010)           seq = '{1, 2, 12};
        else begin
            seq   = '{1, 2, 0};
            legal = 1'b0;
        end
        foreach (seq[i]) begin
            check("state", state_o, seq[i]);
            check("ctrl", obs_ctrl, exp_ctrl(seq[i], fn, z));
            strobes += int'(write_reg) + int'(mem_write);
            if (seq[i] != 1) strobes += int'(pc_write);
            if (i == drop_at) run = 1'b0;
            @(negedge clk);
        end
        if (legal) mdl_cnt = (mdl_cnt + 1) % (1 << CW);
        else       mdl_ill = 1'b1;
        exp_strobes = (!legal || (op == 6'b000100 && !z)) ? 0 : 1;
        check("strobes", strobes, exp_strobes);
        check("count", instr_count, mdl_cnt);
        check("illegal", illegal, mdl_ill);
    endtask

    initial begin
        logic [5:0] rfn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] ops[6] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        logic [5:0] op, fn;

        reset = 1'b1; run = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
        repeat (2) @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_ctrl", obs_ctrl, exp_ctrl(0, 6'd0, 1'b0));
        check("rst_count", instr_count, 0);
        check("rst_illegal", illegal, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_hold", state_o, 0);
        run = 1'b1;
        @(negedge clk);

        exec(6'b000000, 6'b100000, 1'b0, -1);
        exec(6'b100011, 6'b000000, 1'b0, -1);
        exec(6'b000100, 6'b000000, 1'b1, -1);
        exec(6'b000100, 6'b000000, 1'b0, -1);
        exec(6'b111111, 6'b000000, 1'b0, -1);
        exec(6'b101011, 6'b000000, 1'b0, -1);
        exec(6'b000000, 6'b000111, 1'b0, -1);

        // run dropped while addi is executing: it still writes back, then idles
        exec(6'b001000, 6'b000000, 1'b0, 2);
        check("drop_idle", state_o, 0);
        @(negedge clk);
        check("drop_stay", state_o, 0);
        run = 1'b1;
        @(negedge clk);

        // reset in the middle of a load
        opcode = 6'b100011;
        check("lw_if", state_o, 1);
        repeat (3) @(negedge clk);
        check("lw_mrd", state_o, 8);
        reset = 1'b1;
        #1;
        check("rst_async_state", state_o, 0);
        check("rst_async_wr", write_reg, 0);
        @(negedge clk);
        check("rst_held_wr", write_reg, 0);
        check("rst_held_state", state_o, 0);
        mdl_cnt = 0;
        mdl_ill = 1'b0;
        check("rst_mid_count", instr_count, mdl_cnt);
        check("rst_mid_illegal", illegal, mdl_ill);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            int pick = $urandom_range(0, 7);
            fn = 6'($urandom);
            if (pick < 6) begin
                op = ops[pick];
                if (pick == 0) fn = rfn[$urandom_range(0, 4)];
            end else begin
                op = 6'($urandom);
                while (op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010})
                    op = 6'($urandom);
            end
            exec(op, fn, 1'($urandom), -1);
        end

        while (mdl_cnt != (1 << CW) - 1)
            exec(6'b000000, rfn[$urandom_range(0, 4)], 1'b0, -1);
        check("pre_wrap", instr_count, (1 << CW) - 1);
        exec(6'b000010, 6'b000000, 1'b0, -1);
        check("wrap", instr_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
